// File: rtl/lsu_ctrl_if.sv
// Bundled AGU, write-back and memory bus signals of lsu_ctrl.
// master: the controller side; slave: the AGU / write-back / memory environment.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

interface lsu_ctrl_if;
    // AGU command
    logic                  lsu_i_valid;
    logic                  lsu_i_ready;
    logic [`ADDR_SIZE-1:0] lsu_i_addr;
    logic                  lsu_i_read;
    logic [`XLEN-1:0]      lsu_i_wdata;
    logic [`XLEN/8-1:0]    lsu_i_wmask;
    logic [1:0]            lsu_i_size;
    logic                  lsu_i_usign;

    // Write-back
    logic                  lsu_o_valid;
    logic                  lsu_o_ready;
    logic [`XLEN-1:0]      lsu_o_wbck_wdat;
    logic                  lsu_o_err;

    // Memory command
    logic                  mem_cmd_valid;
    logic                  mem_cmd_ready;
    logic [`ADDR_SIZE-1:0] mem_cmd_addr;
    logic                  mem_cmd_read;
    logic [`XLEN-1:0]      mem_cmd_wdata;
    logic [`XLEN/8-1:0]    mem_cmd_wmask;

    // Memory response
    logic                  mem_rsp_valid;
    logic                  mem_rsp_ready;
    logic [`XLEN-1:0]      mem_rsp_rdata;
    logic                  mem_rsp_err;

    modport master (
        input  lsu_i_valid, lsu_i_addr, lsu_i_read, lsu_i_wdata, lsu_i_wmask, lsu_i_size,
               lsu_i_usign,
        output lsu_i_ready,
        output lsu_o_valid, lsu_o_wbck_wdat, lsu_o_err,
        input  lsu_o_ready,
        output mem_cmd_valid, mem_cmd_addr, mem_cmd_read, mem_cmd_wdata, mem_cmd_wmask,
        input  mem_cmd_ready,
        input  mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
        output mem_rsp_ready
    );

    modport slave (
        output lsu_i_valid, lsu_i_addr, lsu_i_read, lsu_i_wdata, lsu_i_wmask, lsu_i_size,
               lsu_i_usign,
        input  lsu_i_ready,
        input  lsu_o_valid, lsu_o_wbck_wdat, lsu_o_err,
        output lsu_o_ready,
        input  mem_cmd_valid, mem_cmd_addr, mem_cmd_read, mem_cmd_wdata, mem_cmd_wmask,
        output mem_cmd_ready,
        output mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: AGU command -> memory bus -> write-back.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_CHK_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module lsu_ctrl (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.master bus
);
    localparam int unsigned XLEN  = `XLEN;
    localparam int unsigned ASIZE = `ADDR_SIZE;
    localparam int unsigned MSIZE = `XLEN / 8;

    typedef enum logic [1:0] {StIdle, StCmd, StRsp, StWbck} state_e;

    state_e           state_q, state_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic             read_q, read_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [MSIZE-1:0] wmask_q, wmask_d;
    logic [1:0]       size_q, size_d;
    logic             usign_q, usign_d;
    logic [XLEN-1:0]  wdat_q, wdat_d;
    logic             err_q, err_d;

    logic             misaligned;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_data;
    logic             lsu_i_ready;
    logic             mem_cmd_valid;
    logic             mem_rsp_ready;
    logic             lsu_o_valid;

`ifdef LSU_MISALIGN_CHK_EN
    // size 11 is treated as a word, so size[1] covers both word encodings.
    assign misaligned = ((bus.lsu_i_size == 2'b01) && bus.lsu_i_addr[0]) ||
                        (bus.lsu_i_size[1] && (bus.lsu_i_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign shifted = bus.mem_rsp_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = shifted;
        case (size_q)
            2'b00:   load_data = {{(XLEN-8){shifted[7] & ~usign_q}}, shifted[7:0]};
            2'b01:   load_data = {{(XLEN-16){shifted[15] & ~usign_q}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        read_d        = read_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        size_d        = size_q;
        usign_d       = usign_q;
        wdat_d        = wdat_q;
        err_d         = err_q;
        lsu_i_ready   = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        lsu_o_valid   = 1'b0;

        unique case (state_q)
            StIdle: begin
                lsu_i_ready = 1'b1;
                if (bus.lsu_i_valid) begin
                    addr_d  = bus.lsu_i_addr;
                    read_d  = bus.lsu_i_read;
                    wdata_d = bus.lsu_i_wdata;
                    wmask_d = bus.lsu_i_wmask;
                    size_d  = bus.lsu_i_size;
                    usign_d = bus.lsu_i_usign;
                    wdat_d  = '0;
                    err_d   = misaligned;
                    state_d = misaligned ? StWbck : StCmd;
                end
            end
            StCmd: begin
                mem_cmd_valid = 1'b1;
                if (bus.mem_cmd_ready) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                mem_rsp_ready = 1'b1;
                if (bus.mem_rsp_valid) begin
                    wdat_d  = read_q ? load_data : '0;
                    err_d   = bus.mem_rsp_err;
                    state_d = StWbck;
                end
            end
            StWbck: begin
                lsu_o_valid = 1'b1;
                if (bus.lsu_o_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            read_q  <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            size_q  <= '0;
            usign_q <= 1'b0;
            wdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            size_q  <= size_d;
            usign_q <= usign_d;
            wdat_q  <= wdat_d;
            err_q   <= err_d;
        end
    end

    assign bus.lsu_i_ready     = lsu_i_ready;
    assign bus.mem_cmd_valid   = mem_cmd_valid;
    assign bus.mem_cmd_addr    = addr_q;
    assign bus.mem_cmd_read    = read_q;
    assign bus.mem_cmd_wdata   = wdata_q;
    assign bus.mem_cmd_wmask   = wmask_q;
    assign bus.mem_rsp_ready   = mem_rsp_ready;
    assign bus.lsu_o_valid     = lsu_o_valid;
    // Result is only presented while the write-back handshake is open.
    assign bus.lsu_o_wbck_wdat = lsu_o_valid ? wdat_q : '0;
    assign bus.lsu_o_err       = lsu_o_valid & err_q;
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL use `XLEN, 32, data width, from defines.v.
REQ-002 SHALL use `ADDR_SIZE, 32, address width, from defines.v.
REQ-003 SHALL have one clock and an asynchronous, active-high reset on the ports below:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
REQ-004 SHALL provide the upstream AGU command port:
- lsu_i_valid  in  1  AGU command valid.
- lsu_i_ready  out  1  command accepted.
- lsu_i_addr  in  `ADDR_SIZE  byte address.
- lsu_i_read  in  1  1=load, 0=store.
- lsu_i_wdata  in  `XLEN  lane-replicated store data.
- lsu_i_wmask  in  `XLEN/8  byte strobes.
- lsu_i_size  in  2  00=B, 01=H, 10=W.
- lsu_i_usign  in  1  zero-extend load.
REQ-005 SHALL provide the write-back port:
- lsu_o_valid  out  1  result valid.
- lsu_o_ready  in  1  write-back accepts.
- lsu_o_wbck_wdat  out  `XLEN  load result; 0 for stores.
- lsu_o_err  out  1  access fault.
REQ-006 SHALL provide the memory command port:
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  command accepted.
- mem_cmd_addr  out  `ADDR_SIZE  address.
- mem_cmd_read  out  1  read.
- mem_cmd_wdata  out  `XLEN  write data.
- mem_cmd_wmask  out  `XLEN/8  strobes.
REQ-007 SHALL provide the memory response port:
- mem_rsp_valid  in  1  response valid.
- mem_rsp_ready  out  1  response accepted.
- mem_rsp_rdata  in  `XLEN  word-aligned read data.
- mem_rsp_err  in  1  bus error.

Function
REQ-008 SHALL implement the FSM states IDLE, CMD, RSP and WBCK, with one transaction outstanding at most.
REQ-009 SHALL assert lsu_i_ready only in IDLE; lsu_i_valid&&lsu_i_ready registers all lsu_i_* fields and moves to CMD (or to WBCK per REQ-015).
REQ-010 SHALL assert mem_cmd_valid only in CMD, with mem_cmd_* driven from registers and held stable until mem_cmd_ready; the handshake moves to RSP.
REQ-011 SHALL assert mem_rsp_ready only in RSP; mem_rsp_valid in RSP registers the result and mem_rsp_err, then moves to WBCK; mem_rsp_valid in any other state is ignored.
REQ-012 SHALL assert lsu_o_valid only in WBCK, with data and error held stable; lsu_o_ready moves to IDLE.
REQ-013 SHALL give a minimum latency of 3 cycles from acceptance (cycle N) to lsu_o_valid (cycle N+3) when mem_cmd_ready and mem_rsp_valid are both high immediately; lsu_i_ready re-asserts at N+4 earliest.
REQ-014 SHALL form load data as rdata >> (addr[1:0]*8):
- B: bits [7:0], sign-extended from bit 7 unless usign.
- H: bits [15:0], sign-extended from bit 15 unless usign.
- W: unchanged.
- size 11: treated as W.
REQ-015 SHALL flag a misaligned access (H with addr[0]=1, or W with addr[1:0]!=0) when checking is enabled: no memory command, direct IDLE->WBCK, lsu_o_err=1, wdat=0.
REQ-016 SHALL complete stores with lsu_o_wbck_wdat=0 and lsu_o_err=mem_rsp_err.
REQ-017 SHALL let lsu_o_ready asserted outside WBCK have no effect.

Reset
REQ-018 SHALL on rst, asynchronously and at any time including mid-transaction, force IDLE, drop any outstanding transaction, and clear all registered fields to 0.
REQ-019 SHALL hold these output values during reset:
- lsu_i_ready=1 after deassertion.
- mem_cmd_valid=0, mem_rsp_ready=0, lsu_o_valid=0.
- lsu_o_wbck_wdat=0, lsu_o_err=0.
- mem_cmd_* data=0.

Configuration
REQ-020 SHALL gate misaligned checking with macro LSU_MISALIGN_CHK_EN: defined gives REQ-015 behaviour; undefined issues every access to memory unmodified and sets lsu_o_err only from mem_rsp_err.

Verification
REQ-021 SHALL cover an LB: addr=0x8000_0003, rdata=0x80FF_FF7F, usign=0 -> wdat=0xFFFF_FF80, err=0, valid at N+3.
REQ-022 SHALL cover an LHU: addr=0x8000_0002, rdata=0xBEEF_1234 -> wdat=0x0000_BEEF.
REQ-023 SHALL cover an SB: addr=0x8000_0001, wdata=0x5A5A_5A5A, wmask=0010 -> one mem command with identical fields; rsp_err=1 -> wdat=0, err=1.
REQ-024 SHALL cover backpressure: mem_cmd_ready low 4 cycles, lsu_o_ready low 3 cycles -> outputs stable, lsu_i_ready=0 throughout, exactly one memory command.
REQ-025 SHALL cover LW at addr=0x8000_0002 with LSU_MISALIGN_CHK_EN defined -> no mem_cmd_valid, lsu_o_valid at N+1, err=1; with the macro undefined -> memory access issued, err=0.
REQ-026 SHALL cover rst pulsed in RSP -> IDLE next edge, mem_rsp_ready=0; a late mem_rsp_valid is ignored, lsu_o_valid stays 0.
